// File: rtl/ycbcr_rgb.sv
// YCbCr 4:2:2 word stream to RGB888 / RGB565 converter.
// Phase tracker pairs two lumas with shared chroma, then a 3-stage fixed-point datapath.
module ycbcr_rgb (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        frame_start,
   input  logic        pre_wr_en,
   input  logic [15:0] ycbcr_data,
   output logic        wr_en_dly,
   output logic [15:0] rgb565_data,
   output logic [7:0]  img_r,
   output logic [7:0]  img_g,
   output logic [7:0]  img_b
);

   logic       phase_q, phase_d;
   logic       pend_q, pend_d;
   logic [7:0] y0_q, y0_d;
   logic [7:0] y1_q, y1_d;
   logic [7:0] cb_q, cb_d;
   logic [7:0] cr_q, cr_d;

   logic       iss_v_q, iss_v_d;
   logic [7:0] iss_y_q, iss_y_d;
   logic [7:0] iss_cb_q, iss_cb_d;
   logic [7:0] iss_cr_q, iss_cr_d;

   logic               s1_v_q, s1_v_d;
   logic signed [17:0] s1_y_q, s1_y_d;
   logic signed [17:0] s1_rcr_q, s1_rcr_d;
   logic signed [17:0] s1_gcb_q, s1_gcb_d;
   logic signed [17:0] s1_gcr_q, s1_gcr_d;
   logic signed [17:0] s1_bcb_q, s1_bcb_d;

   logic               s2_v_q, s2_v_d;
   logic signed [17:0] s2_r_q, s2_r_d;
   logic signed [17:0] s2_g_q, s2_g_d;
   logic signed [17:0] s2_b_q, s2_b_d;

   logic        out_v_q, out_v_d;
   logic [7:0]  out_r_q, out_r_d;
   logic [7:0]  out_g_q, out_g_d;
   logic [7:0]  out_b_q, out_b_d;
   logic [15:0] out_p_q, out_p_d;

   logic [8:0]         cb_s, cr_s;
   logic signed [17:0] cb_x, cr_x;

   // Pixel 1 of a pair always issues the cycle after pixel 0; the next
   // pair's phase-0 word cannot issue, so the two never collide.
   always_comb begin
      phase_d  = phase_q;
      pend_d   = 1'b0;
      y0_d     = y0_q;
      y1_d     = y1_q;
      cb_d     = cb_q;
      cr_d     = cr_q;
      iss_v_d  = 1'b0;
      iss_y_d  = '0;
      iss_cb_d = '0;
      iss_cr_d = '0;
      if (pend_q) begin
         iss_v_d  = 1'b1;
         iss_y_d  = y1_q;
         iss_cb_d = cb_q;
         iss_cr_d = cr_q;
      end
      if (pre_wr_en) begin
         if (frame_start || !phase_q) begin
            y0_d    = ycbcr_data[15:8];
            cb_d    = ycbcr_data[7:0];
            phase_d = 1'b1;
         end else begin
            iss_v_d  = 1'b1;
            iss_y_d  = y0_q;
            iss_cb_d = cb_q;
            iss_cr_d = ycbcr_data[7:0];
            y1_d     = ycbcr_data[15:8];
            cr_d     = ycbcr_data[7:0];
            pend_d   = 1'b1;
            phase_d  = 1'b0;
         end
      end else if (frame_start) begin
         phase_d = 1'b0;
      end
   end

   always_comb begin
      cb_s = {1'b0, iss_cb_q} - 9'd128;
      cr_s = {1'b0, iss_cr_q} - 9'd128;
      cb_x = $signed({{9{cb_s[8]}}, cb_s});
      cr_x = $signed({{9{cr_s[8]}}, cr_s});
      s1_v_d   = iss_v_q;
      s1_y_d   = $signed({2'b00, iss_y_q, 8'h00});
      s1_rcr_d = cr_x * 18'sd359;
      s1_gcb_d = cb_x * 18'sd88;
      s1_gcr_d = cr_x * 18'sd183;
      s1_bcb_d = cb_x * 18'sd454;
   end

   always_comb begin
      s2_v_d = s1_v_q;
      s2_r_d = s1_y_q + s1_rcr_q;
      s2_g_d = s1_y_q - s1_gcb_q - s1_gcr_q;
      s2_b_d = s1_y_q + s1_bcb_q;
   end

   function automatic logic [7:0] clamp8(input logic signed [17:0] v);
      logic signed [17:0] s;
      s = v >>> 8;
      if (s[17])          return 8'd0;
      else if (|s[16:8])  return 8'd255;
      else                return s[7:0];
   endfunction

   // Idle cycles drive zeros rather than holding the last pixel.
   always_comb begin
      out_v_d = s2_v_q;
      out_r_d = '0;
      out_g_d = '0;
      out_b_d = '0;
      if (s2_v_q) begin
         out_r_d = clamp8(s2_r_q);
         out_g_d = clamp8(s2_g_q);
         out_b_d = clamp8(s2_b_q);
      end
      out_p_d = {out_r_d[7:3], out_g_d[7:2], out_b_d[7:3]};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_q  <= 1'b0;
         pend_q   <= 1'b0;
         y0_q     <= '0;
         y1_q     <= '0;
         cb_q     <= '0;
         cr_q     <= '0;
         iss_v_q  <= 1'b0;
         iss_y_q  <= '0;
         iss_cb_q <= '0;
         iss_cr_q <= '0;
         s1_v_q   <= 1'b0;
         s1_y_q   <= '0;
         s1_rcr_q <= '0;
         s1_gcb_q <= '0;
         s1_gcr_q <= '0;
         s1_bcb_q <= '0;
         s2_v_q   <= 1'b0;
         s2_r_q   <= '0;
         s2_g_q   <= '0;
         s2_b_q   <= '0;
         out_v_q  <= 1'b0;
         out_r_q  <= '0;
         out_g_q  <= '0;
         out_b_q  <= '0;
         out_p_q  <= '0;
      end else begin
         phase_q  <= phase_d;
         pend_q   <= pend_d;
         y0_q     <= y0_d;
         y1_q     <= y1_d;
         cb_q     <= cb_d;
         cr_q     <= cr_d;
         iss_v_q  <= iss_v_d;
         iss_y_q  <= iss_y_d;
         iss_cb_q <= iss_cb_d;
         iss_cr_q <= iss_cr_d;
         s1_v_q   <= s1_v_d;
         s1_y_q   <= s1_y_d;
         s1_rcr_q <= s1_rcr_d;
         s1_gcb_q <= s1_gcb_d;
         s1_gcr_q <= s1_gcr_d;
         s1_bcb_q <= s1_bcb_d;
         s2_v_q   <= s2_v_d;
         s2_r_q   <= s2_r_d;
         s2_g_q   <= s2_g_d;
         s2_b_q   <= s2_b_d;
         out_v_q  <= out_v_d;
         out_r_q  <= out_r_d;
         out_g_q  <= out_g_d;
         out_b_q  <= out_b_d;
         out_p_q  <= out_p_d;
      end
   end

   assign wr_en_dly   = out_v_q;
   assign img_r       = out_r_q;
   assign img_g       = out_g_q;
   assign img_b       = out_b_q;
   assign rgb565_data = out_p_q;

endmodule
